// File: rtl/lms_spi_slave_regs.sv
// ---------------------------------------------------------------------------
// lms_spi_slave_regs
//
// SPI responder (mode 0) for LMS7-style 32-bit frames, serving a bank of
// 16-bit configuration registers to FPGA logic. The SPI pins are oversampled
// in the clk domain, so no flop is clocked by SCLK.
//
// Frame (MSB first): bit31 = 1 write / 0 read, bits30:16 = address,
// bits15:0 = data. MOSI is sampled on SCLK rise events. MISO changes on
// SCLK fall events.
//
// Ports:
//   clk          system clock
//   reset_n      synchronous active-low reset
//   spi_ss_n     chip select, active low (asynchronous)
//   spi_sclk     SPI clock, mode 0 (asynchronous)
//   spi_mosi     master-out data (asynchronous)
//   spi_miso     slave-out data, forced to 0 whenever spi_miso_oe is 0
//   spi_miso_oe  MISO drive enable for the top-level tri-state/mux
//   regs_q       flat register contents, register k at [16k+15:16k]
//   wr_stb       one-cycle pulse when a register has been written
//   wr_addr      register index of the last write
//
// Write notification: wr_stb is a single-cycle pulse with no back-pressure.
// In the cycle wr_stb is high, wr_addr holds the written index and regs_q
// already shows the new value. wr_addr keeps its value until the next write.
// ---------------------------------------------------------------------------
module lms_spi_slave_regs #(
  parameter logic [14:0] ADDR_BASE    = 15'h0000,
  parameter int          NREGS        = 32,
  parameter int          SCLK_DIV_MIN = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  spi_ss_n,
  input  logic                  spi_sclk,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  output logic [NREGS*16-1:0]   regs_q,
  output logic                  wr_stb,
  output logic [7:0]            wr_addr
);

  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Pin synchronizers. Stages [0] and [1] form the 2-FF synchronizer, and
  // stage [2] is the delayed copy used for edge detection. MOSI needs only the
  // 2-FF stage because it is consumed at the same depth as SCLK stage [1].
  // These flops are deliberately not reset: they must keep tracking the pins
  // during reset so the FSM can see whether ss_n is low when reset releases.
  // -------------------------------------------------------------------------
  logic [2:0] ss_sr;
  logic [2:0] sclk_sr;
  logic [1:0] mosi_sr;

  always_ff @(posedge clk) begin
    ss_sr   <= {ss_sr[1:0], spi_ss_n};
    sclk_sr <= {sclk_sr[1:0], spi_sclk};
    mosi_sr <= {mosi_sr[0], spi_mosi};
  end

  logic ss_lvl, ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_bit;

  assign ss_lvl    = ss_sr[1];
  assign ss_fall   =  ss_sr[2]   & ~ss_sr[1];
  assign ss_rise   = ~ss_sr[2]   &  ss_sr[1];
  assign sclk_rise = ~sclk_sr[2] &  sclk_sr[1];
  assign sclk_fall =  sclk_sr[2] & ~sclk_sr[1];
  assign mosi_bit  = mosi_sr[1];

  // -------------------------------------------------------------------------
  // Datapath state.
  // -------------------------------------------------------------------------
  state_t         state, state_nxt;
  logic [4:0]     bit_cnt;      // 0..15 in CMD, 16..31 in DATA
  logic [14:0]    cmd_sr;       // first 15 command bits; the 16th comes live
  logic [15:0]    data_sr;
  logic [15:0]    rd_sr;
  logic           is_wr;
  logic           hit;
  logic [IW-1:0]  idx;
  logic           commit_pend;
  logic [15:0]    regs [NREGS];

  // Command decode on the 16th rise: the last bit is still on mosi_bit.
  logic [15:0]    cmd_word;
  logic [14:0]    cmd_diff;
  logic           cmd_hit;
  logic [IW-1:0]  cmd_idx;
  logic [7:0]     idx_ext;

  assign cmd_word = {cmd_sr, mosi_bit};
  assign cmd_diff = cmd_word[14:0] - ADDR_BASE;
  // Unsigned compare: addresses below ADDR_BASE wrap to large values and miss.
  assign cmd_hit  = ({17'd0, cmd_diff} < 32'(NREGS));
  assign cmd_idx  = cmd_diff[IW-1:0];

  always_comb begin
    idx_ext = '0;
    idx_ext[IW-1:0] = idx;
  end

  // -------------------------------------------------------------------------
  // FSM: state register.
  // When reset releases with ss_n already low, the frame in progress has an
  // unknown prefix, so it is parked in DONE until ss_n goes high.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ss_lvl ? IDLE : DONE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state and frame-phase strobes. An ss_n rise always takes
  // priority over a coincident SCLK rise, so a frame whose last rise has not
  // yet been counted is aborted.
  logic cmd_done, data_done, cmd_shift, data_shift, rd_shift;

  always_comb begin
    state_nxt  = state;
    cmd_done   = 1'b0;
    data_done  = 1'b0;
    cmd_shift  = 1'b0;
    data_shift = 1'b0;
    rd_shift   = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) state_nxt = CMD;
      end
      CMD: begin
        if (ss_rise) begin
          state_nxt = IDLE;
        end else if (sclk_rise) begin
          cmd_shift = 1'b1;
          if (bit_cnt == 5'd15) begin
            cmd_done  = 1'b1;
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (ss_rise) begin
          state_nxt = IDLE;
        end else begin
          rd_shift = sclk_fall;
          if (sclk_rise) begin
            data_shift = 1'b1;
            if (bit_cnt == 5'd31) begin
              data_done = 1'b1;
              state_nxt = DONE;
            end
          end
        end
      end
      DONE: begin
        if (ss_rise) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath and register bank.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bit_cnt     <= '0;
      cmd_sr      <= '0;
      data_sr     <= '0;
      rd_sr       <= '0;
      is_wr       <= 1'b0;
      hit         <= 1'b0;
      idx         <= '0;
      commit_pend <= 1'b0;
      wr_stb      <= 1'b0;
      wr_addr     <= '0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      for (int k = 0; k < NREGS; k++) begin
        regs[k] <= '0;
      end
    end else begin
      wr_stb      <= 1'b0;
      commit_pend <= 1'b0;

      // The commit lands one clk after the 32nd rise. It is independent of
      // the FSM, so an ss_n rise in that same cycle cannot cancel it.
      if (commit_pend) begin
        regs[idx] <= data_sr;
        wr_stb    <= 1'b1;
        wr_addr   <= idx_ext;
      end

      if (cmd_shift || data_shift) begin
        bit_cnt <= bit_cnt + 5'd1;
      end

      if (cmd_shift) begin
        cmd_sr <= cmd_word[14:0];
      end

      if (cmd_done) begin
        is_wr <= cmd_word[15];
        hit   <= cmd_hit;
        idx   <= cmd_idx;
        if (!cmd_word[15] && cmd_hit) begin
          rd_sr       <= regs[cmd_idx];
          spi_miso_oe <= 1'b1;
        end
      end

      if (data_shift && is_wr) begin
        data_sr <= {data_sr[14:0], mosi_bit};
      end

      // spi_miso_oe is only set for a read hit, so it gates the shift-out.
      if (rd_shift && spi_miso_oe) begin
        spi_miso <= rd_sr[15];
        rd_sr    <= {rd_sr[14:0], 1'b0};
      end

      if (data_done && is_wr && hit) begin
        commit_pend <= 1'b1;
      end

      // Leaving the frame (normal end or abort) releases MISO and clears the
      // bit counter. This is placed last so it overrides the updates above.
      if (state_nxt == IDLE) begin
        bit_cnt     <= '0;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NREGS; k++) begin : g_regs_q
    assign regs_q[16*k +: 16] = regs[k];
  end

`ifndef SYNTHESIS
  // SCLK must be slow enough for the 3-clk synchronizer lag. Allow one clk of
  // sampling jitter between two measured rise events.
  logic [15:0] sclk_gap;
  logic        sclk_seen;

  always_ff @(posedge clk) begin
    if (!reset_n || state == IDLE) begin
      sclk_gap  <= '0;
      sclk_seen <= 1'b0;
    end else if (sclk_rise) begin
      sclk_gap  <= 16'd1;
      sclk_seen <= 1'b1;
    end else if (sclk_gap != 16'hFFFF) begin
      sclk_gap  <= sclk_gap + 16'd1;
    end
  end

  always @(posedge clk) begin
    if (reset_n && sclk_rise && sclk_seen && (state == CMD || state == DATA)) begin
      assert (32'(sclk_gap) >= SCLK_DIV_MIN - 1)
        else $error("SCLK period %0d clk is below SCLK_DIV_MIN %0d", sclk_gap, SCLK_DIV_MIN);
    end
  end
`endif

endmodule
